// File: rtl/serial_const_undo.sv
// Bit-serial undo of the add/sub-constant datapath: recovers X from Y, LSB first through one full adder.
// Latency WIDTH edges after accept; no overlap; result held in DONE while out_ready is low, in_ready low until handshake.
module serial_const_undo #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_const_sel,
    input  logic             in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           stateQ;
    state_t           stateD;
    logic [WIDTH-1:0] aQ;
    logic [WIDTH-1:0] bQ;
    logic [WIDTH-1:0] resQ;
    logic             carryQ;
    logic [CW-1:0]    cntQ;

    logic             accept;
    logic             lastBit;
    logic             sumBit;
    logic             carryNext;
    logic [WIDTH-1:0] kVal;

    assign in_ready  = (stateQ == IDLE) && rst_n;
    assign accept    = in_valid && in_ready;
    assign lastBit   = (cntQ == CW'(WIDTH - 1));
    assign kVal      = {{(WIDTH-3){1'b0}}, in_const_sel, 1'b1};
    assign sumBit    = aQ[0] ^ bQ[0] ^ carryQ;
    assign carryNext = (aQ[0] & bQ[0]) | ((aQ[0] ^ bQ[0]) & carryQ);

    always_comb begin
        stateD = stateQ;
        case (stateQ)
            IDLE:    if (accept)    stateD = SHIFT;
            SHIFT:   if (lastBit)   stateD = DONE;
            DONE:    if (out_ready) stateD = IDLE;
            default:                stateD = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) stateQ <= IDLE;
        else        stateQ <= stateD;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            aQ        <= '0;
            bQ        <= '0;
            resQ      <= '0;
            carryQ    <= 1'b0;
            cntQ      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_carry <= 1'b0;
        end else begin
            case (stateQ)
                IDLE: begin
                    if (accept) begin
                        aQ     <= in_data;
                        // Undoing an add is Y + ~K + 1; undoing a subtract is Y + K.
                        bQ     <= in_op ? kVal : ~kVal;
                        carryQ <= ~in_op;
                        cntQ   <= '0;
                    end
                end
                SHIFT: begin
                    aQ     <= aQ >> 1;
                    bQ     <= bQ >> 1;
                    resQ   <= {sumBit, resQ[WIDTH-1:1]};
                    carryQ <= carryNext;
                    cntQ   <= cntQ + CW'(1);
                    if (lastBit) begin
                        out_data  <= {sumBit, resQ[WIDTH-1:1]};
                        out_carry <= carryNext;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: out_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_const_undo.sv
// Directed and round-trip checks for serial_const_undo (WIDTH=8).
module tb_serial_const_undo;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [1:0] in_const_sel;
    logic       in_op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_carry;

    int nCompared;
    int nMismatched;

    logic [8:0] expQ[$];

    serial_const_undo #(.WIDTH(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_const_sel (in_const_sel),
        .in_op        (in_op),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_carry    (out_carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic stepClk();
        @(posedge clk);
        #1;
    endtask

    task automatic startTxn(input logic [7:0] y, input logic [1:0] sel, input logic op);
        in_data      = y;
        in_const_sel = sel;
        in_op        = op;
        in_valid     = 1'b1;
        checkVal("in_ready_before_accept", in_ready, 1);
        stepClk();
        in_valid = 1'b0;
    endtask

    task automatic waitValid(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            stepClk();
            n++;
        end
        checkVal("out_valid_rise", out_valid, 1);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        stepClk();
        out_ready = 1'b0;
        checkVal("out_valid_after_hs", out_valid, 0);
        checkVal("in_ready_after_hs", in_ready, 1);
    endtask

    task automatic doTxn(input string tag, input logic [7:0] y, input logic [1:0] sel,
                         input logic op, input logic [7:0] expD, input logic expC);
        int n;
        startTxn(y, sel, op);
        waitValid(n);
        checkVal({tag, "_latency"}, n, 8);
        checkVal({tag, "_data"}, out_data, expD);
        checkVal({tag, "_carry"}, out_carry, expC);
        handshake();
    endtask

    initial begin
        int  n;
        int  sawValid;
        logic [7:0] held;

        nCompared    = 0;
        nMismatched  = 0;
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        in_const_sel = '0;
        in_op        = 1'b0;
        out_ready    = 1'b0;

        repeat (3) stepClk();
        checkVal("rst_in_ready", in_ready, 0);
        checkVal("rst_out_valid", out_valid, 0);
        checkVal("rst_out_data", out_data, 0);
        checkVal("rst_out_carry", out_carry, 0);
        rst_n = 1'b1;
        #1;
        checkVal("post_rst_in_ready", in_ready, 1);
        stepClk();

        doTxn("add_undo", 8'h0A, 2'd2, 1'b0, 8'h05, 1'b1);
        doTxn("underflow", 8'h00, 2'd0, 1'b0, 8'hFF, 1'b0);
        doTxn("sub_ovf", 8'hFC, 2'd3, 1'b1, 8'h03, 1'b1);
        doTxn("sub_plain", 8'h10, 2'd1, 1'b1, 8'h13, 1'b0);

        // Backpressure: hold the result for 5 cycles while a stray input arrives.
        startTxn(8'h0A, 2'd2, 1'b0);
        waitValid(n);
        held = out_data;
        checkVal("bp_data", held, 8'h05);
        for (int c = 0; c < 5; c++) begin
            in_valid = (c == 2);
            in_data  = 8'h55;
            checkVal("bp_out_valid", out_valid, 1);
            checkVal("bp_out_data", out_data, held);
            checkVal("bp_in_ready", in_ready, 0);
            stepClk();
        end
        in_valid = 1'b0;
        handshake();
        stepClk();
        stepClk();
        checkVal("bp_stray_not_taken", in_ready, 1);
        checkVal("bp_no_extra_valid", out_valid, 0);

        // Reset while SHIFT is at cnt=4.
        startTxn(8'h33, 2'd0, 1'b0);
        repeat (4) stepClk();
        rst_n = 1'b0;
        stepClk();
        checkVal("midrst_out_valid", out_valid, 0);
        checkVal("midrst_out_data", out_data, 0);
        checkVal("midrst_out_carry", out_carry, 0);
        checkVal("midrst_in_ready", in_ready, 0);
        rst_n = 1'b1;
        #1;
        checkVal("midrst_in_ready_rel", in_ready, 1);
        sawValid = 0;
        for (int c = 0; c < 10; c++) begin
            stepClk();
            if (out_valid) sawValid = 1;
        end
        checkVal("midrst_no_pulse", sawValid, 0);
        doTxn("after_rst", 8'h80, 2'd1, 1'b0, 8'h7D, 1'b1);

        // Round trip with random valid/ready on both sides.
        fork
            begin : producer
                int k;
                int x;
                int y;
                int sel;
                int op;
                int tries;
                logic fire;
                logic ok;
                logic ec;
                for (int i = 0; i < 2048; i++) begin
                    x   = i % 256;
                    sel = (i / 256) % 4;
                    op  = i / 1024;
                    k   = 2 * sel + 1;
                    y   = (op == 0) ? (x + k) % 256 : (x - k + 256) % 256;
                    ec  = (op == 0) ? (y >= k) : (y + k > 255);
                    in_data      = y[7:0];
                    in_const_sel = sel[1:0];
                    in_op        = op[0];
                    ok    = 1'b0;
                    tries = 0;
                    while (!ok && tries < 300) begin
                        in_valid = 1'($urandom_range(0, 1));
                        fire     = in_valid && in_ready;
                        stepClk();
                        if (fire) begin
                            ok = 1'b1;
                            expQ.push_back({ec, x[7:0]});
                        end
                        tries++;
                    end
                    in_valid = 1'b0;
                    if (!ok) begin
                        checkVal("rt_accept_timeout", 0, 1);
                        break;
                    end
                end
            end
            begin : consumer
                int got;
                int cyc;
                logic fire;
                logic [8:0] e;
                got = 0;
                cyc = 0;
                while (got < 2048 && cyc < 80000) begin
                    out_ready = 1'($urandom_range(0, 1));
                    fire      = out_valid && out_ready;
                    stepClk();
                    cyc++;
                    if (fire) begin
                        if (expQ.size() == 0) begin
                            checkVal("rt_unexpected_result", 1, 0);
                        end else begin
                            e = expQ.pop_front();
                            checkVal("rt_data", out_data, e[7:0]);
                            checkVal("rt_carry", out_carry, e[8]);
                        end
                        got++;
                    end
                end
                out_ready = 1'b0;
                checkVal("rt_count", got, 2048);
            end
        join
        checkVal("rt_queue_empty", expQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
